// File: rtl/genie_credit_tx.sv
// Credit-based link transmitter: forwards upstream beats onto a ready-less link while it holds far-end credit.
// Define GENIE_CREDIT_TX_CHECK_EN to build the sticky credit-overflow checker driving o_err.
module genie_credit_tx #(
  parameter int WIDTH   = 1,
  parameter int CREDITS = 4,
  localparam int CNTW   = $clog2(CREDITS + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_credit,
  output logic [CNTW-1:0]  o_credits,
  output logic             o_err
);

  localparam logic [CNTW-1:0] FULL = CNTW'(CREDITS);
  localparam logic [CNTW-1:0] ONE  = CNTW'(1);

  logic [CNTW-1:0] count;
  logic            send;

  // Ready depends only on the registered count, so upstream sees no path from the link side
  assign o_ready   = (count != '0);
  assign send      = i_valid && o_ready;
  assign o_credits = count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count <= FULL;
    end else begin
      case ({send, i_credit})
        2'b10:   count <= count - ONE;
        2'b01:   count <= (count == FULL) ? FULL : count + ONE;
        default: count <= count;
      endcase
    end
  end

  // Link payload keeps its last value between beats; only o_valid marks a new one
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= send;
      if (send) begin
        o_data <= i_data;
      end
    end
  end

`ifdef GENIE_CREDIT_TX_CHECK_EN
  logic overflow;

  // A credit arriving while already full means the far end returned more than it was given
  assign overflow = i_credit && !send && (count == FULL);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_err <= 1'b0;
    end else if (overflow) begin
      o_err <= 1'b1;
    end
  end
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_genie_credit_tx.sv
// Self-checking bench for genie_credit_tx (WIDTH=8, CREDITS=4): directed cases plus random traffic
// against a credit/queue reference model with a 3-cycle-delayed 4-deep receiver.
module tb_genie_credit_tx;

  localparam int WIDTH   = 8;
  localparam int CREDITS = 4;
  localparam int CNTW    = $clog2(CREDITS + 1);

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             i_credit;
  logic [CNTW-1:0]  o_credits;
  logic             o_err;

  genie_credit_tx #(.WIDTH(WIDTH), .CREDITS(CREDITS)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .i_credit (i_credit),
    .o_credits(o_credits),
    .o_err    (o_err)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: what the link should show after the last clock edge
  int         m_credits;
  bit         m_valid;
  logic [7:0] m_data;
  bit         m_err;
  int         cyc;
  bit         order_chk;
  int         ret_q[$];
  logic [7:0] order_q[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_credits = CREDITS;
    m_valid   = 1'b0;
    m_data    = 8'h00;
    m_err     = 1'b0;
    ret_q.delete();
    order_q.delete();
  endtask

  // Check the current outputs against the model, then drive one cycle of inputs and advance the model
  task automatic applyStimulus(input bit v, input logic [7:0] d, input bit c);
    bit send;
    bit overflow;
    @(negedge i_clk);
    checkOutput("ready",   {31'b0, o_ready},  {31'b0, (m_credits != 0)});
    checkOutput("credits", 32'(o_credits),    m_credits);
    checkOutput("valid",   {31'b0, o_valid},  {31'b0, m_valid});
    checkOutput("data",    32'(o_data),       32'(m_data));
    checkOutput("err",     {31'b0, o_err},    {31'b0, m_err});
    if (order_chk && o_valid) begin
      if (order_q.size() == 0) checkOutput("order_empty", 32'd1, 32'd0);
      else                     checkOutput("order", 32'(o_data), 32'(order_q.pop_front()));
    end
    i_valid  = v;
    i_data   = d;
    i_credit = c;
    send     = v && (m_credits > 0);
    overflow = c && !send && (m_credits == CREDITS);
    m_credits = m_credits - int'(send) + int'(c);
    if (m_credits > CREDITS) m_credits = CREDITS;
`ifdef GENIE_CREDIT_TX_CHECK_EN
    if (overflow) m_err = 1'b1;
`else
    if (overflow) m_err = 1'b0;
`endif
    m_valid = send;
    if (send) begin
      m_data = d;
      if (order_chk) order_q.push_back(d);
    end
    @(posedge i_clk);
    cyc++;
  endtask

  task automatic sync_reset_cycles(input int n);
    @(negedge i_clk);
    i_reset  = 1'b1;
    i_valid  = 1'b1;
    i_credit = 1'b1;
    i_data   = 8'hA5;
    repeat (n) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("rst_ready",   {31'b0, o_ready},  32'd1);
    checkOutput("rst_credits", 32'(o_credits),    CREDITS);
    checkOutput("rst_valid",   {31'b0, o_valid},  32'd0);
    i_reset  = 1'b0;
    i_valid  = 1'b0;
    i_credit = 1'b0;
    model_reset();
  endtask

  initial begin
    cyc       = 0;
    order_chk = 1'b0;
    i_reset   = 1'b1;
    i_valid   = 1'b0;
    i_credit  = 1'b0;
    i_data    = 8'h00;
    model_reset();
    #1;
    checkOutput("por_valid",   {31'b0, o_valid}, 32'd0);
    checkOutput("por_data",    32'(o_data),      32'd0);
    checkOutput("por_credits", 32'(o_credits),   CREDITS);
    checkOutput("por_err",     {31'b0, o_err},   32'd0);
    sync_reset_cycles(2);

    // Four sends drain all credit; held data at zero credit is not taken
    applyStimulus(1, 8'h11, 0);
    applyStimulus(1, 8'h22, 0);
    applyStimulus(1, 8'h33, 0);
    applyStimulus(1, 8'h44, 0);
    applyStimulus(1, 8'h55, 0);
    applyStimulus(1, 8'h55, 0);
    // Credit pulse at zero: one bubble, then the held beat goes out
    applyStimulus(1, 8'h55, 1);
    applyStimulus(1, 8'h55, 0);
    applyStimulus(0, 8'h00, 0);
    applyStimulus(0, 8'h00, 0);

    // Refill to 2, then ten sends each paired with a returned credit
    applyStimulus(0, 8'h00, 1);
    applyStimulus(0, 8'h00, 1);
    for (int i = 0; i < 10; i++) applyStimulus(1, 8'($urandom), 1);
    applyStimulus(0, 8'h00, 0);

    // Refill to full, then an extra credit must saturate (and flag when the checker is built)
    applyStimulus(0, 8'h00, 1);
    applyStimulus(0, 8'h00, 1);
    applyStimulus(0, 8'h00, 1);
    applyStimulus(0, 8'h00, 0);
    applyStimulus(0, 8'h00, 0);

    // Asynchronous reset mid-cycle with a beat in flight and one credit left
    sync_reset_cycles(1);
    applyStimulus(1, 8'hC1, 0);
    applyStimulus(1, 8'hC2, 0);
    applyStimulus(1, 8'hC3, 0);
    #2;
    i_reset = 1'b1;
    #1;
    checkOutput("arst_valid",   {31'b0, o_valid}, 32'd0);
    checkOutput("arst_data",    32'(o_data),      32'd0);
    checkOutput("arst_credits", 32'(o_credits),   CREDITS);
    checkOutput("arst_ready",   {31'b0, o_ready}, 32'd1);
    checkOutput("arst_err",     {31'b0, o_err},   32'd0);
    i_valid  = 1'b1;
    i_credit = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("arst_hold_credits", 32'(o_credits), CREDITS);
    checkOutput("arst_hold_valid",   {31'b0, o_valid}, 32'd0);
    i_reset  = 1'b0;
    i_valid  = 1'b0;
    i_credit = 1'b0;
    model_reset();
    applyStimulus(0, 8'h00, 0);

    // Random traffic against a receiver that returns each credit 3 cycles after the beat arrives
    order_chk = 1'b1;
    for (int i = 0; i < 400; i++) begin
      bit v;
      bit c;
      v = ($urandom_range(0, 1) == 1);
      c = (ret_q.size() > 0) && (ret_q[0] == cyc);
      if (c) void'(ret_q.pop_front());
      if (v && (m_credits > 0)) ret_q.push_back(cyc + 4);
      applyStimulus(v, 8'($urandom), c);
    end
    for (int i = 0; i < 8; i++) begin
      bit c;
      c = (ret_q.size() > 0) && (ret_q[0] == cyc);
      if (c) void'(ret_q.pop_front());
      applyStimulus(0, 8'h00, c);
    end
    checkOutput("final_credits", 32'(o_credits), CREDITS);
    checkOutput("final_err",     {31'b0, o_err}, 32'd0);
    checkOutput("order_drained", order_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/genie_credit_tx.md
GENIE_CREDIT_TX -- requirements
Module: genie_credit_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1: data payload width in bits.
REQ-002 The block SHALL have parameter CREDITS, default 4: initial credit count, equal to the far-end receiver buffer depth; legal range 1..255.
REQ-003 The block SHALL have derived localparam CNTW = $clog2(CREDITS+1): credit counter width.
REQ-004 The block SHALL have port i_clk, input, 1: clock; all state SHALL update on the rising edge.
REQ-005 The block SHALL have port i_reset, input, 1: reset, asynchronous, active-high.
REQ-006 The block SHALL have port i_data, input, WIDTH: upstream payload.
REQ-007 The block SHALL have port i_valid, input, 1: upstream payload valid.
REQ-008 The block SHALL have port o_ready, output, 1: upstream may transfer this cycle.
REQ-009 The block SHALL have port o_data, output, WIDTH: link payload, registered.
REQ-010 The block SHALL have port o_valid, output, 1: link payload valid, registered; there is no downstream ready.
REQ-011 The block SHALL have port i_credit, input, 1: one-cycle pulse, one credit returned per asserted cycle.
REQ-012 The block SHALL have port o_credits, output, CNTW: current credit count.
REQ-013 The block SHALL have port o_err, output, 1: sticky credit-overflow flag.

Function
REQ-014 Upstream transfer ("send") SHALL occur in any cycle where i_valid && o_ready.
REQ-015 o_ready SHALL equal (credit count != 0), decoded from the registered counter only, with no combinational path from i_valid, i_data or i_credit.
REQ-016 On a send, o_valid SHALL be 1 and o_data SHALL equal the sent i_data on the following cycle; latency is exactly 1 cycle.
REQ-017 In a cycle without a send, o_valid SHALL be 0 on the next cycle and o_data SHALL hold its previous value.
REQ-018 Next credit count SHALL be count - send + i_credit, as an unsigned CNTW-bit value.
REQ-019 A simultaneous send and i_credit SHALL leave the count unchanged.
REQ-020 At count 0, o_ready SHALL be 0, no send SHALL occur, and i_valid SHALL be ignored.
REQ-021 At count 0 with i_credit=1, count SHALL become 1 and o_ready SHALL be 1 on the next cycle; the credit-to-ready bubble is exactly 1 cycle.
REQ-022 At count CREDITS with i_credit=1 and no send (overflow), count SHALL saturate at CREDITS and not wrap to 0.
REQ-023 Back-to-back sends SHALL be sustained at one per cycle while count > 0.
REQ-024 o_credits SHALL reflect the registered counter directly.

Reset
REQ-025 Asserting i_reset SHALL immediately set o_valid=0, o_data=0, count=CREDITS, o_err=0; o_ready SHALL therefore be 1 during and after reset.
REQ-026 Reset mid-operation SHALL discard in-flight link state and restore full credit; the far-end receiver SHALL be reset on the same i_reset.
REQ-027 i_credit and i_valid SHALL be ignored while i_reset is asserted.

Configuration
REQ-028 Macro GENIE_CREDIT_TX_CHECK_EN SHALL gate the overflow checker.
REQ-029 With GENIE_CREDIT_TX_CHECK_EN defined, an overflow event per REQ-022 SHALL set o_err=1 on the next cycle, and o_err SHALL remain 1 until reset.
REQ-030 Without GENIE_CREDIT_TX_CHECK_EN defined, o_err SHALL be tied 0; the port SHALL still exist, and saturation per REQ-022 SHALL be retained.

Verification (WIDTH=8, CREDITS=4)
REQ-031 Reset release, i_valid=1, data 0x11,0x22,0x33,0x44 on consecutive cycles, no credits -> o_valid high for 4 cycles with o_data 0x11..0x44, each 1 cycle after its send; o_credits 4,3,2,1,0; o_ready=0 after the 4th send.
REQ-032 Count 0, i_valid=1 data 0x55 held, i_credit pulse in cycle N -> o_ready=1 at N+1, send at N+1, o_valid=1 with o_data=0x55 at N+2, o_credits 0->1->0.
REQ-033 Count 2, send with i_credit=1 in the same cycle for 10 cycles -> o_credits stays 2, 10 consecutive o_valid beats.
REQ-034 Count 4, i_credit=1 with i_valid=0 -> o_credits stays 4; o_err=1 next cycle with macro defined, o_err=0 without it.
REQ-035 Count 1 with o_valid=1, assert i_reset asynchronously mid-cycle -> o_valid=0, o_data=0x00, o_credits=4, o_ready=1 immediately; o_err cleared.
REQ-036 Random i_valid (50%) and credit returns via a 3-cycle-delayed model of a 4-deep receiver -> no count underflow, no overflow, o_err=0, and output order matches input order.
